dmem_ws_rv32i: RTL and testbench

DMEM_WS_RV32I -- requirements
Module: dmem_ws_rv32i

---
 rtl/dmem_ws_rv32i.sv | 169 ++++++++++++++++
 tb/tb_dmem_ws_rv32i.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/dmem_ws_rv32i.sv
// RV32I data memory with a fixed number of wait states and little-endian byte lanes.
// Optional `DMEM_ALIGN_CHECK_EN: fault misaligned H/W accesses and out-of-range addresses.
module dmem_ws_rv32i #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [2:0]  type_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic          accept, enter_resp, do_write;
  logic          cur_we;
  logic [2:0]    cur_type;
  logic [31:0]   cur_addr, cur_wdata;
  logic [AW-1:0] cur_idx;
  logic          cur_err;
  logic [31:0]   word, load_data, shifted, wshift, bmask;
  logic [3:0]    lane_mask;
  logic          unused_addr;

  assign req_ready = (state_q == StIdle) && !reset;
  assign rsp_valid = (state_q == StResp);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign accept    = req_valid && req_ready;

  // In IDLE the live inputs are used so a zero-wait access completes on its accepting edge.
  always_comb begin
    cur_we    = we_q;
    cur_type  = type_q;
    cur_addr  = addr_q;
    cur_wdata = wdata_q;
    if (state_q == StIdle) begin
      cur_we    = req_we;
      cur_type  = req_type;
      cur_addr  = req_addr;
      cur_wdata = req_wdata;
    end
  end

  assign cur_idx     = cur_addr[AW+1:2];
  assign unused_addr = ^cur_addr;

`ifdef DMEM_ALIGN_CHECK_EN
  always_comb begin
    cur_err = (cur_type == 3'b011) || (cur_type == 3'b110) || (cur_type == 3'b111);
    if ((cur_type[1:0] == 2'b01) && cur_addr[0]) cur_err = 1'b1;
    if ((cur_type[1:0] == 2'b10) && (cur_addr[1:0] != 2'b00)) cur_err = 1'b1;
    if ((cur_addr >> (AW + 2)) != 32'd0) cur_err = 1'b1;
  end
`else
  assign cur_err = (cur_type == 3'b011) || (cur_type == 3'b110) || (cur_type == 3'b111);
`endif

  always_comb begin
    word      = mem[cur_idx];
    shifted   = word >> {cur_addr[1:0], 3'b000};
    load_data = 32'd0;
    lane_mask = 4'b0000;
    wshift    = cur_wdata;
    case (cur_type)
      3'b000: begin
        load_data = {{24{shifted[7]}}, shifted[7:0]};
        lane_mask = 4'b0001 << cur_addr[1:0];
        wshift    = {4{cur_wdata[7:0]}};
      end
      3'b100: load_data = {24'd0, shifted[7:0]};
      3'b001: begin
        load_data = cur_addr[1] ? {{16{word[31]}}, word[31:16]} : {{16{word[15]}}, word[15:0]};
        lane_mask = cur_addr[1] ? 4'b1100 : 4'b0011;
        wshift    = {2{cur_wdata[15:0]}};
      end
      3'b101: load_data = cur_addr[1] ? {16'd0, word[31:16]} : {16'd0, word[15:0]};
      3'b010: begin
        load_data = word;
        lane_mask = 4'b1111;
      end
      default: ;
    endcase
    bmask = {{8{lane_mask[3]}}, {8{lane_mask[2]}}, {8{lane_mask[1]}}, {8{lane_mask[0]}}};
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (WAIT_STATES == 0) begin
            state_d    = StResp;
            enter_resp = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = 4'(WAIT_STATES);
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d    = StResp;
          enter_resp = 1'b1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign do_write = enter_resp && cur_we && !cur_err;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      type_q  <= 3'b000;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= req_we;
        type_q  <= req_type;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (enter_resp) begin
        err_q   <= cur_err;
        rdata_q <= (cur_err || cur_we) ? 32'd0 : load_data;
      end else if (state_q == StResp) begin
        err_q   <= 1'b0;
        rdata_q <= 32'd0;
      end
    end
  end

  // No reset on the array: contents survive reset.
  always_ff @(posedge clock) begin
    if (do_write) mem[cur_idx] <= (mem[cur_idx] & ~bmask) | (wshift & bmask);
  end

endmodule

// File: tb/tb_dmem_ws_rv32i.sv
// Directed bench: a WAIT_STATES=3 instance for function/timing/reset, and a
// WAIT_STATES=0 instance for zero-wait latency; both share clock, reset and request fields.
module tb_dmem_ws_rv32i;
  localparam int unsigned DEPTH = 64;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        valid3 = 1'b0, valid0 = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_type = 3'b010;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic        ready3, ready0, v3, v0, err3, err0;
  logic [31:0] rdata3, rdata0;

  int ncmp = 0;
  int nerr = 0;

  always #5 clock = ~clock;

  dmem_ws_rv32i #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(3)) dut (
    .clock(clock), .reset(reset), .req_valid(valid3), .req_ready(ready3), .req_we(req_we),
    .req_type(req_type), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(v3),
    .rsp_rdata(rdata3), .rsp_err(err3)
  );

  dmem_ws_rv32i #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) dut0 (
    .clock(clock), .reset(reset), .req_valid(valid0), .req_ready(ready0), .req_we(req_we),
    .req_type(req_type), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(v0),
    .rsp_rdata(rdata0), .rsp_err(err0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One access on the selected instance; fields are scrambled right after acceptance.
  task automatic access(input bit sel, input logic we, input logic [2:0] typ,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_data, input logic exp_err,
                        input int exp_lat, input string tag);
    int lat = 0;
    logic rdy_ok = 1'b1;
    logic [31:0] got = 32'hx;
    logic gerr = 1'bx;
    @(negedge clock);
    req_we = we; req_type = typ; req_addr = addr; req_wdata = wdata;
    if (sel) valid0 = 1'b1; else valid3 = 1'b1;
    chk({tag, " ready"}, 32'(sel ? ready0 : ready3), 32'd1);
    @(posedge clock);
    #1;
    valid0 = 1'b0; valid3 = 1'b0;
    req_we = ~we; req_type = 3'b111; req_addr = ~addr; req_wdata = ~wdata;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      if ((sel ? ready0 : ready3) !== 1'b0) rdy_ok = 1'b0;
      if ((sel ? v0 : v3) === 1'b1) begin
        lat = k; got = sel ? rdata0 : rdata3; gerr = sel ? err0 : err3;
        break;
      end
    end
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " rdata"}, got, exp_data);
    chk({tag, " err"}, 32'(gerr), 32'(exp_err));
    chk({tag, " ready low while busy"}, 32'(rdy_ok), 32'd1);
    @(negedge clock);
    chk({tag, " pulse ends"}, 32'(sel ? v0 : v3), 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clock);
    chk("reset ready", 32'(ready3), 32'd0);
    chk("reset rsp_valid", 32'(v3), 32'd0);
    chk("reset rdata", rdata3, 32'd0);
    chk("reset err", 32'(err3), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("ready after reset", 32'(ready3), 32'd1);

    access(0, 1, 3'b010, 32'h0, 32'hDEADBEEF, 32'h0, 0, 4, "SW @0");
    access(0, 0, 3'b010, 32'h0, 32'h0, 32'hDEADBEEF, 0, 4, "LW @0");
    access(0, 1, 3'b000, 32'h1, 32'h123456AA, 32'h0, 0, 4, "SB @1");
    access(0, 0, 3'b010, 32'h0, 32'h0, 32'hDEADAAEF, 0, 4, "LW after SB");
    access(0, 0, 3'b000, 32'h1, 32'h0, 32'hFFFFFFAA, 0, 4, "LB @1");
    access(0, 0, 3'b100, 32'h1, 32'h0, 32'h000000AA, 0, 4, "LBU @1");
    access(0, 1, 3'b001, 32'h2, 32'hFFFF1234, 32'h0, 0, 4, "SH @2");
    access(0, 0, 3'b010, 32'h0, 32'h0, 32'h1234AAEF, 0, 4, "LW after SH");
    access(0, 0, 3'b001, 32'h2, 32'h0, 32'h00001234, 0, 4, "LH @2");
    access(0, 0, 3'b001, 32'h0, 32'h0, 32'hFFFFAAEF, 0, 4, "LH @0");
    access(0, 0, 3'b101, 32'h0, 32'h0, 32'h0000AAEF, 0, 4, "LHU @0");
    access(0, 0, 3'b000, 32'h3, 32'h0, 32'h00000012, 0, 4, "LB @3");
    access(0, 1, 3'b011, 32'h0, 32'h0, 32'h0, 1, 4, "bad type store");
    access(0, 0, 3'b110, 32'h0, 32'h0, 32'h0, 1, 4, "bad type load");
    access(0, 0, 3'b010, 32'h0, 32'h0, 32'h1234AAEF, 0, 4, "LW after bad store");
    access(0, 1, 3'b010, 32'h4, 32'h01020304, 32'h0, 0, 4, "SW @4");
`ifdef DMEM_ALIGN_CHECK_EN
    access(0, 1, 3'b010, 32'h6, 32'hCAFEBABE, 32'h0, 1, 4, "SW misaligned");
    access(0, 0, 3'b010, 32'h4, 32'h0, 32'h01020304, 0, 4, "LW @4 unchanged");
    access(0, 0, 3'b010, DEPTH * 4, 32'h0, 32'h0, 1, 4, "LW out of range");
    access(0, 0, 3'b001, 32'h1, 32'h0, 32'h0, 1, 4, "LH misaligned");
`else
    access(0, 1, 3'b010, 32'h6, 32'hCAFEBABE, 32'h0, 0, 4, "SW misaligned");
    access(0, 0, 3'b010, 32'h4, 32'h0, 32'hCAFEBABE, 0, 4, "LW @4 aligned lane");
    access(0, 0, 3'b010, DEPTH * 4, 32'h0, 32'h1234AAEF, 0, 4, "LW wraps");
    access(0, 0, 3'b001, 32'h3, 32'h0, 32'h00001234, 0, 4, "LH misaligned");
`endif

    // Reset pulsed in the second WAIT cycle must abandon the store.
    access(0, 1, 3'b010, 32'h8, 32'h55667788, 32'h0, 0, 4, "SW @8 prior");
    @(negedge clock);
    req_we = 1'b1; req_type = 3'b010; req_addr = 32'h8; req_wdata = 32'h11111111;
    valid3 = 1'b1;
    @(posedge clock);
    #1;
    valid3 = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    chk("mid-wait reset ready", 32'(ready3), 32'd0);
    chk("mid-wait reset rsp_valid", 32'(v3), 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    begin
      logic seen = 1'b0;
      for (int k = 0; k < 6; k++) begin
        @(negedge clock);
        if (v3 === 1'b1) seen = 1'b1;
      end
      chk("no response after reset", 32'(seen), 32'd0);
    end
    chk("ready after mid-wait reset", 32'(ready3), 32'd1);
    access(0, 0, 3'b010, 32'h8, 32'h0, 32'h55667788, 0, 4, "LW @8 prior kept");

    access(1, 1, 3'b010, 32'h0, 32'h00000077, 32'h0, 0, 1, "ws0 SW");
    access(1, 0, 3'b010, 32'h0, 32'h0, 32'h00000077, 0, 1, "ws0 LW");
    access(1, 0, 3'b100, 32'h0, 32'h0, 32'h00000077, 0, 1, "ws0 LBU");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
